// File: rtl/ecc_secded_decoder.sv
// SECDED read-side checker for the shared-memory ECC path.
// Recomputes the Hamming syndrome and the overall parity of a stored codeword.
// Single-bit errors are corrected when enabled, and multi-bit errors are flagged.
// The result is registered behind a valid/ready stage.
// Saturating sec/ded counters feed the repair logic.
module ecc_secded_decoder #(
  parameter int DATA_WIDTH    = 32,
  parameter int PARITY_LENGTH = 6,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH+PARITY_LENGTH:0]   codeword_in,
  input  logic                                correct_en,
  input  logic                                cnt_clr,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               d_out,
  output logic [PARITY_LENGTH-1:0]            syndrome_out,
  output logic                                sec_err,
  output logic                                ded_err,
  output logic [CNT_WIDTH-1:0]                sec_cnt,
  output logic [CNT_WIDTH-1:0]                ded_cnt
);

  localparam int N = DATA_WIDTH + PARITY_LENGTH;

  // Hamming position that holds data bit k: the k-th non-power-of-two position, counting up from 3.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic [PARITY_LENGTH-1:0] syn;
  logic                     par;
  logic                     syn_in_range;
  logic                     sec_w;
  logic                     ded_w;
  logic                     do_flip;
  logic [DATA_WIDTH-1:0]    data_fix;
  logic                     accept;

  // Syndrome is the XOR of the indices of all set bits; par covers the whole word including bit 0
  always_comb begin
    syn = '0;
    for (int p = 1; p <= N; p++) begin
      if (codeword_in[p]) syn = syn ^ PARITY_LENGTH'(p);
    end
    par = ^codeword_in;
  end

  // Classify: odd parity means a single error, unless the syndrome points outside the word
  always_comb begin
    syn_in_range = (int'(syn) <= N);
    sec_w        = par & syn_in_range;
    ded_w        = (par & ~syn_in_range) | (~par & (syn != '0));
    do_flip      = correct_en & sec_w & (syn != '0);
  end

  // The only data bit that can be repaired is the one whose position equals the syndrome.
  // A bit-0 error never touches the data.
  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_extract
    localparam int POS = data_pos(k);
    assign data_fix[k] = codeword_in[POS] ^ (do_flip & (syn == PARITY_LENGTH'(POS)));
  end

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Output stage: load on accept, hold while stalled, drop valid once consumed with nothing new
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      d_out        <= '0;
      syndrome_out <= '0;
      sec_err      <= 1'b0;
      ded_err      <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      d_out        <= data_fix;
      syndrome_out <= syn;
      sec_err      <= sec_w;
      ded_err      <= ded_w;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Saturating error counters, counted at the accept edge; a clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (accept) begin
      if (sec_w && !(&sec_cnt)) sec_cnt <= sec_cnt + CNT_WIDTH'(1);
      if (ded_w && !(&ded_cnt)) ded_cnt <= ded_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Scoreboard bench for ecc_secded_decoder.
// Each codeword is a golden-encoded word with a known set of flipped positions.
// The expected result is derived from that flip set.
module tb_ecc_secded_decoder;

  localparam int DW = 32;
  localparam int PL = 6;
  localparam int CW = 4;
  localparam int N  = DW + PL;

  typedef struct {
    logic [DW-1:0] d;
    logic [PL-1:0] syn;
    logic          sec;
    logic          ded;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N:0]    codeword_in;
  logic          correct_en;
  logic          cnt_clr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] d_out;
  logic [PL-1:0] syndrome_out;
  logic          sec_err;
  logic          ded_err;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] ded_cnt;

  logic [DW-1:0] cur_data;
  logic [N:0]    cur_mask;

  int vectors     = 0;
  int miscompares = 0;
  int dpos[DW];

  exp_t          q[$];
  logic [CW-1:0] m_sec = '0;
  logic [CW-1:0] m_ded = '0;
  logic          armed = 1'b0;
  logic          post_rst = 1'b0;

  ecc_secded_decoder #(.DATA_WIDTH(DW), .PARITY_LENGTH(PL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .correct_en(correct_en), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
    .syndrome_out(syndrome_out), .sec_err(sec_err), .ded_err(ded_err),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [N:0] encode(input logic [DW-1:0] d);
    logic [N:0] cw;
    logic b;
    cw = '0;
    for (int k = 0; k < DW; k++) cw[dpos[k]] = d[k];
    for (int i = 0; i < PL; i++) begin
      b = 1'b0;
      for (int p = 1; p <= N; p++) if (((p >> i) & 1) == 1) b = b ^ cw[p];
      cw[1 << i] = b;
    end
    cw[0] = ^cw[N:1];
    return cw;
  endfunction

  // The flip set alone decides the outcome, because a clean codeword has a zero syndrome and even parity.
  function automatic exp_t predict(input logic [DW-1:0] d, input logic [N:0] mask, input logic ce);
    exp_t e;
    int s, nf;
    logic [N:0] flips;
    s = 0;
    nf = 0;
    for (int p = 0; p <= N; p++) if (mask[p]) begin nf++; s = s ^ p; end
    e.syn = PL'(s);
    e.sec = (nf % 2 == 1) && (s <= N);
    e.ded = ((nf % 2 == 1) && (s > N)) || ((nf % 2 == 0) && (s != 0));
    flips = mask;
    if (e.sec && ce && s != 0) flips[s] = ~flips[s];
    e.d = d;
    for (int k = 0; k < DW; k++) if (flips[dpos[k]]) e.d[k] = ~e.d[k];
    return e;
  endfunction

  function automatic logic [N:0] bm(input int p);
    logic [N:0] m;
    m = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [N:0] rand_mask();
    logic [N:0] m;
    int r, n, p;
    m = '0;
    r = int'($urandom_range(0, 9));
    n = (r < 3) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
    for (int i = 0; i < n; i++) begin
      p = int'($urandom_range(0, N));
      m[p] = ~m[p];
    end
    return m;
  endfunction

  // Monitor: compare what the DUT shows now, then predict what the coming edge will do
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    logic acc;
    ev = (q.size() != 0);
    if (armed) begin
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !ev || out_ready);
      if (ev) begin
        e = q[0];
        chk("d_out", d_out, e.d);
        chk("syndrome_out", syndrome_out, e.syn);
        chk("sec_err", sec_err, e.sec);
        chk("ded_err", ded_err, e.ded);
      end
      if (post_rst) begin
        chk("rst_d_out", d_out, 0);
        chk("rst_syndrome", syndrome_out, 0);
        chk("rst_sec_err", sec_err, 0);
        chk("rst_ded_err", ded_err, 0);
        chk("rst_in_ready", in_ready, 1);
        post_rst = 1'b0;
      end
      chk("sec_cnt", sec_cnt, m_sec);
      chk("ded_cnt", ded_cnt, m_ded);
    end
    if (rst) begin
      q.delete();
      m_sec = '0;
      m_ded = '0;
      post_rst = 1'b1;
      armed = 1'b1;
    end else if (armed) begin
      acc = in_valid && (!ev || out_ready);
      if (ev && out_ready) void'(q.pop_front());
      if (acc) begin
        e = predict(cur_data, cur_mask, correct_en);
        q.push_back(e);
      end
      if (cnt_clr) begin
        m_sec = '0;
        m_ded = '0;
      end else if (acc) begin
        if (e.sec && m_sec != '1) m_sec = m_sec + 1'b1;
        if (e.ded && m_ded != '1) m_ded = m_ded + 1'b1;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [N:0] m, input logic ce);
    int waitc;
    cur_data    = d;
    cur_mask    = m;
    codeword_in = encode(d) ^ m;
    correct_en  = ce;
    in_valid    = 1'b1;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    chk("send_accept_within_budget", (waitc < 50), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [DW-1:0] d, input logic [PL-1:0] s,
                            input logic sec, input logic ded);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_d_out"}, d_out, d);
    chk({nm, "_syndrome"}, syndrome_out, s);
    chk({nm, "_sec"}, sec_err, sec);
    chk({nm, "_ded"}, ded_err, ded);
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    cnt = 0;
    for (int p = 1; p <= N; p++) if ((p & (p - 1)) != 0 && cnt < DW) begin dpos[cnt] = p; cnt++; end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; correct_en = 1'b0;
    cur_data = '0; cur_mask = '0; codeword_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // clean zero word
    send('0, '0, 1'b1);
    expect_out("t1", '0, '0, 1'b0, 1'b0);
    chk("t1_sec_cnt", sec_cnt, 0);
    chk("t1_ded_cnt", ded_cnt, 0);

    // single error at position 5 (data bit 1), with and without correction
    send(32'hF000_0000, bm(5), 1'b1);
    expect_out("t2c", 32'hF000_0000, 6'd5, 1'b1, 1'b0);
    chk("t2_sec_cnt", sec_cnt, 1);
    send(32'hF000_0000, bm(5), 1'b0);
    expect_out("t2n", 32'hF000_0002, 6'd5, 1'b1, 1'b0);

    // double error at positions 3 and 5, then a lone overall-parity error
    send('0, bm(3) | bm(5), 1'b1);
    expect_out("t3d", 32'h0000_0003, 6'd6, 1'b0, 1'b1);
    chk("t3_ded_cnt", ded_cnt, 1);
    send('0, bm(0), 1'b1);
    expect_out("t3p", '0, '0, 1'b1, 1'b0);
    chk("t3_sec_cnt", sec_cnt, 3);

    // consumer stalls for several cycles while the producer keeps offering words
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send($urandom, bm(int'($urandom_range(0, N))), 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) step();

    // drive the sec counter into saturation, then clear it alongside another sec error
    for (int i = 0; i < 18; i++) send($urandom, bm(int'($urandom_range(1, N))), 1'b1);
    @(negedge clk);
    chk("t5_sec_sat", sec_cnt, 15);
    step();
    cnt_clr = 1'b1;
    send($urandom, bm(7), 1'b1);
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("t5_sec_clr", sec_cnt, 0);
    chk("t5_ded_clr", ded_cnt, 0);
    step();

    // reset while a result is stalled at the output
    out_ready = 1'b0;
    send($urandom, bm(3) | bm(9), 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_d_out", d_out, 0);
    chk("t6_ded_cnt", ded_cnt, 0);
    chk("t6_in_ready", in_ready, 1);
    step();
    out_ready = 1'b1;

    // random traffic with random back-pressure, clears and occasional resets
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      cnt_clr    = ($urandom_range(0, 49) == 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      correct_en = ($urandom_range(0, 1) == 1);
      cur_data   = $urandom;
      cur_mask   = rand_mask();
      codeword_in = encode(cur_data) ^ cur_mask;
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (5) step();
    chk("drain_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
